// File: rtl/dds_wave_gen.sv
// rtl/dds_wave_gen.sv - DDS waveform generator: phase accumulator, arithmetic saw/tri/square/DC, amplitude scaling
// All state updates on the falling clock edge; pipeline is acc -> phase -> wave -> scaled output.
module dds_wave_gen #(
  parameter int ACC_W   = 16,
  parameter int PHASE_W = 7,
  parameter int OUT_W   = 16,
  parameter int AMP_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [ACC_W-1:0]   ftw,
  input  logic [PHASE_W-1:0] phase,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] duty,
  input  logic [AMP_W-1:0]   amp,
  input  logic               enable,
  output logic [OUT_W-1:0]   wave_out,
  output logic               out_valid,
  output logic               wrap
);

  localparam int PROD_W = OUT_W + AMP_W;

  logic [ACC_W-1:0]   ftw_s;
  logic [PHASE_W-1:0] phase_s;
  logic [PHASE_W-1:0] duty_s;
  logic [1:0]         sel_s;
  logic [AMP_W-1:0]   amp_s;

  logic [ACC_W-1:0]   acc;
  logic               carry;
  logic [PHASE_W-1:0] p;
  logic               v1, w1;
  logic [OUT_W-1:0]   w;
  logic               v2, w2;

  logic [PHASE_W-1:0] tri_t;
  logic [OUT_W-1:0]   w_next;
  logic [AMP_W:0]     gain;
  logic [PROD_W-1:0]  prod;

  // Triangle folds the phase: rising ramp in the first half, inverted ramp in the second.
  always_comb begin
    tri_t  = p[PHASE_W-1] ? ~{p[PHASE_W-2:0], 1'b0} : {p[PHASE_W-2:0], 1'b0};
    w_next = '0;
    case (sel_s)
      2'd0:    w_next = OUT_W'(p) << (OUT_W - PHASE_W);
      2'd1:    w_next = OUT_W'(tri_t) << (OUT_W - PHASE_W);
      2'd2:    w_next = (p < duty_s) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
      default: w_next = OUT_W'(1) << (OUT_W - 1);
    endcase
  end

  // gain = amp+1 so that amp all-ones is exact unity after the >> AMP_W.
  assign gain = {1'b0, amp_s} + (AMP_W+1)'(1);
  assign prod = PROD_W'(w) * PROD_W'(gain);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      ftw_s     <= '0;
      phase_s   <= '0;
      duty_s    <= '0;
      sel_s     <= '0;
      amp_s     <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      p         <= '0;
      v1        <= 1'b0;
      w1        <= 1'b0;
      w         <= '0;
      v2        <= 1'b0;
      w2        <= 1'b0;
      wave_out  <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      if (load) begin
        ftw_s   <= ftw;
        phase_s <= phase;
        duty_s  <= duty;
        sel_s   <= wave_sel;
        amp_s   <= amp;
      end
      // Carry is cleared while frozen so a stale overflow never tags a later sample.
      if (enable) {carry, acc} <= {1'b0, acc} + {1'b0, ftw_s};
      else        carry        <= 1'b0;

      p         <= acc[ACC_W-1 -: PHASE_W] + phase_s;
      v1        <= enable;
      w1        <= carry & enable;

      w         <= w_next;
      v2        <= v1;
      w2        <= w1;

      wave_out  <= OUT_W'(prod >> AMP_W);
      out_valid <= v2;
      wrap      <= w2;
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb/tb_dds_wave_gen.sv - scoreboard bench for dds_wave_gen
// Inputs change on the rising edge, outputs are sampled on the rising edge (DUT uses the falling edge).
module tb_dds_wave_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] ftw = '0;
  logic [6:0]  phase = '0;
  logic [1:0]  wave_sel = '0;
  logic [6:0]  duty = '0;
  logic [7:0]  amp = '0;
  logic        enable = 1'b0;
  logic [15:0] wave_out;
  logic        out_valid;
  logic        wrap;

  dds_wave_gen #(.ACC_W(16), .PHASE_W(7), .OUT_W(16), .AMP_W(8)) dut (
    .clk(clk), .reset(reset), .load(load), .ftw(ftw), .phase(phase),
    .wave_sel(wave_sel), .duty(duty), .amp(amp), .enable(enable),
    .wave_out(wave_out), .out_valid(out_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] w;
    logic        wr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  int   acc_m, ftw_m, phase_m, duty_m, sel_m, amp_m;
  logic carry_m;

  function automatic logic [15:0] model_wave(input int pidx, input int sel, input int dty, input int am);
    int t;
    int wv;
    t  = 0;
    wv = 0;
    case (sel)
      0: wv = pidx * 512;
      1: begin
        t  = (pidx < 64) ? 2 * pidx : 255 - 2 * pidx;
        wv = t * 512;
      end
      2: wv = (pidx < dty) ? 65535 : 0;
      default: wv = 32768;
    endcase
    return 16'((wv * (am + 1)) >> 8);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic sample_out();
    exp_t e;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_underflow observed=valid sample 0x%0h expected=no sample", wave_out);
      end else begin
        e = q.pop_front();
        check("wave", {16'h0, wave_out}, {16'h0, e.w});
        check("wrap", {31'h0, wrap}, {31'h0, e.wr});
      end
    end
  endtask

  task automatic tick(input logic en, input logic ld);
    exp_t e;
    int   pidx;
    enable = en;
    load   = ld;
    if (en) begin
      pidx = ((acc_m >> 9) + phase_m) & 127;
      e.w  = model_wave(pidx, sel_m, duty_m, amp_m);
      e.wr = carry_m;
      q.push_back(e);
    end
    @(negedge clk);
    if (en) begin
      carry_m = (acc_m + ftw_m) > 65535;
      acc_m   = (acc_m + ftw_m) & 65535;
    end else begin
      carry_m = 1'b0;
    end
    if (ld) begin
      ftw_m   = ftw;
      phase_m = phase;
      duty_m  = duty;
      sel_m   = wave_sel;
      amp_m   = amp;
    end
    @(posedge clk);
    sample_out();
  endtask

  task automatic model_reset();
    q.delete();
    acc_m = 0; ftw_m = 0; phase_m = 0; duty_m = 0; sel_m = 0; amp_m = 0;
    carry_m = 1'b0;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    load   = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
  endtask

  task automatic setctl(input int f, input int sel, input int dty, input int ph, input int am, input logic en);
    ftw      = 16'(f);
    wave_sel = 2'(sel);
    duty     = 7'(dty);
    phase    = 7'(ph);
    amp      = 8'(am);
    tick(en, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() != 0; i++) tick(1'b0, 1'b0);
    check("drain_empty", q.size(), 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    check("rst_wave", {16'h0, wave_out}, 0);
    check("rst_valid", {31'h0, out_valid}, 0);
    check("rst_wrap", {31'h0, wrap}, 0);
    #2 reset = 1'b0;
    @(posedge clk);

    // Saw ramp with valid latency and wraps every 128 samples
    do_reset();
    setctl(16'h0200, 0, 0, 0, 8'hFF, 1'b0);
    tick(1'b1, 1'b0);
    check("valid_lat1", {31'h0, out_valid}, 0);
    tick(1'b1, 1'b0);
    check("valid_lat2", {31'h0, out_valid}, 0);
    tick(1'b1, 1'b0);
    check("valid_lat3", {31'h0, out_valid}, 1);
    for (int i = 0; i < 257; i++) tick(1'b1, 1'b0);
    drain();

    // Triangle over one full period
    do_reset();
    setctl(16'h0200, 1, 0, 0, 8'hFF, 1'b0);
    for (int i = 0; i < 130; i++) tick(1'b1, 1'b0);
    drain();

    // Square duty 0x20, then duty 0
    do_reset();
    setctl(16'h0200, 2, 7'h20, 0, 8'hFF, 1'b0);
    for (int i = 0; i < 128; i++) tick(1'b1, 1'b0);
    drain();
    setctl(16'h0200, 2, 0, 0, 8'hFF, 1'b0);
    for (int i = 0; i < 128; i++) tick(1'b1, 1'b0);
    drain();

    // Amplitude scaling on saw, then DC at unity gain
    do_reset();
    setctl(16'h0200, 0, 0, 0, 8'h7F, 1'b0);
    for (int i = 0; i < 128; i++) tick(1'b1, 1'b0);
    drain();
    setctl(16'h0200, 3, 0, 0, 8'hFF, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    drain();

    // Phase offset, then ftw reload while running
    do_reset();
    setctl(16'h0200, 0, 0, 7'h40, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    setctl(16'h0400, 0, 0, 7'h40, 8'hFF, 1'b1);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
    drain();

    // Asynchronous reset mid-ramp
    do_reset();
    setctl(16'h0200, 0, 0, 0, 8'hFF, 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_wave", {16'h0, wave_out}, 0);
    check("async_rst_valid", {31'h0, out_valid}, 0);
    check("async_rst_wrap", {31'h0, wrap}, 0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
